// File: rtl/attention_loader_if.sv
// Purpose: valid/ready element stream feeding attention_loader.
// Signals:
//   in_valid  source -> loader  element valid
//   in_ready  loader -> source  element ready
//   in_data   source -> loader  signed WIDTH-bit element
// Modports: master = stream source, slave = attention_loader.
interface attention_loader_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/attention_loader.sv
// Purpose: stream-to-matrix front end for Attention. Collects a row-major
//   frame of In, WQ, WK, WV elements from a valid/ready stream, fires a
//   one-cycle START, then holds the matrices until DONE comes back.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   strm         element stream (attention_loader_if.slave)
//   reuse_w      request weight reuse for the next frame
//   In/WQ/WK/WV  matrices to Attention
//   START        one-cycle start pulse to Attention
//   DONE         completion from Attention (level or pulse)
//   busy         high while loading, firing or waiting
//   frame_done   one-cycle pulse when DONE is accepted
// Option: define ATTN_LOADER_WEIGHT_REUSE_EN to allow In-only frames that
//   keep the previously loaded WQ/WK/WV.
module attention_loader #(
    parameter int unsigned N     = 4,
    parameter int unsigned D     = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    attention_loader_if.slave                       strm,
    input  logic                                    reuse_w,
    output logic signed [N-1:0][D-1:0][WIDTH-1:0]   In,
    output logic signed [D-1:0][D-1:0][WIDTH-1:0]   WQ,
    output logic signed [D-1:0][D-1:0][WIDTH-1:0]   WK,
    output logic signed [D-1:0][D-1:0][WIDTH-1:0]   WV,
    output logic                                    START,
    input  logic                                    DONE,
    output logic                                    busy,
    output logic                                    frame_done
);
    localparam int unsigned IN_ELEMS = N * D;
    localparam int unsigned W_ELEMS  = D * D;
    localparam int unsigned TOTAL    = IN_ELEMS + 3 * W_ELEMS;
    localparam int unsigned CW       = $clog2(TOTAL + 1);
    localparam int unsigned AW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [TOTAL-1:0][WIDTH-1:0] mem_q;
    logic                        start_q, busy_q, frame_done_q;
    logic                        done_pend_q;
    logic                        ready_c, accept_c, last_c, done_acc_c;
    int unsigned                 len_c;

`ifdef ATTN_LOADER_WEIGHT_REUSE_EN
    logic reuse_q, weights_valid_q, reuse_eff_c;

    // reuse_w only counts on the opening beat; later beats follow the latched choice
    assign reuse_eff_c = (state_q == S_IDLE) ? (reuse_w && weights_valid_q) : reuse_q;
    assign len_c       = reuse_eff_c ? IN_ELEMS : TOTAL;
`else
    logic unused_reuse_w;

    assign unused_reuse_w = reuse_w;
    assign len_c          = TOTAL;
`endif

    // Ready is withheld while reset is asserted, not just after it takes effect
    assign ready_c       = !reset && (state_q == S_IDLE || state_q == S_LOAD);
    assign strm.in_ready = ready_c;
    assign accept_c      = strm.in_valid && ready_c;
    assign last_c        = (cnt_q == CW'(len_c - 1));

    // Flat element store, row-major In then WQ, WK, WV; packed layout matches the ports
    assign In = mem_q[IN_ELEMS-1:0];
    assign WQ = mem_q[IN_ELEMS+W_ELEMS-1:IN_ELEMS];
    assign WK = mem_q[IN_ELEMS+2*W_ELEMS-1:IN_ELEMS+W_ELEMS];
    assign WV = mem_q[TOTAL-1:IN_ELEMS+2*W_ELEMS];

    assign START      = start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Next-state and element counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_acc_c = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept_c) begin
                    if (last_c) begin
                        state_d = S_FIRE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_LOAD;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            S_FIRE: state_d = S_WAIT;
            S_WAIT: begin
                // DONE seen during FIRE is remembered and completes here
                if (DONE || done_pend_q) begin
                    done_acc_c = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, element store and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            mem_q           <= '0;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            done_pend_q     <= 1'b0;
`ifdef ATTN_LOADER_WEIGHT_REUSE_EN
            reuse_q         <= 1'b0;
            weights_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= (state_d == S_FIRE);
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= done_acc_c;
            done_pend_q  <= (state_q == S_FIRE) && DONE;
            if (accept_c) begin
                mem_q[AW'(cnt_q)] <= strm.in_data;
            end
`ifdef ATTN_LOADER_WEIGHT_REUSE_EN
            if (accept_c && state_q == S_IDLE) begin
                reuse_q <= reuse_w && weights_valid_q;
            end
            if (accept_c && last_c && !reuse_eff_c) begin
                weights_valid_q <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_attention_loader.sv
// Purpose: self-checking bench for attention_loader. A table of frame
//   descriptors drives the stream; each written element is queued as an
//   expectation and checked against the matrices once START appears.
module tb_attention_loader;
    localparam int N     = 4;
    localparam int D     = 4;
    localparam int WIDTH = 8;
    localparam int NE    = N * D;
    localparam int TOTAL = NE + 3 * D * D;

    typedef struct {
        string name;
        bit    reuse;
        int    nbeats;   // expected frame length: START must follow this beat
        int    base;     // beat k carries base+k
        bit    gap;      // idle cycle before every beat
        bit    done_mid; // pulse DONE during the load
        int    hold;     // cycles DONE is held in WAIT
    } vec_t;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] val;
    } sb_t;

    logic clk = 1'b0;
    logic reset, reuse_w, DONE, START, busy, frame_done;
    logic signed [N-1:0][D-1:0][WIDTH-1:0] in_m;
    logic signed [D-1:0][D-1:0][WIDTH-1:0] wq_m, wk_m, wv_m;

    attention_loader_if #(.WIDTH(WIDTH)) s_if ();

    attention_loader #(.N(N), .D(D), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .strm       (s_if),
        .reuse_w    (reuse_w),
        .In         (in_m),
        .WQ         (wq_m),
        .WK         (wk_m),
        .WV         (wv_m),
        .START      (START),
        .DONE       (DONE),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    sb_t              sb_q[$];
    logic [WIDTH-1:0] exp_mem[TOTAL];
    vec_t             vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_elem(input int k);
        logic [TOTAL*WIDTH-1:0] flat;
        flat = {wv_m, wk_m, wq_m, in_m};
        return flat[k*WIDTH +: WIDTH];
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset         = 1'b1;
        s_if.in_valid = 1'b0;
        DONE          = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("ready_in_reset", 32'(s_if.in_ready), 32'd0);
        end
        chk("start_after_reset", 32'(START), 32'd0);
        chk("busy_after_reset", 32'(busy), 32'd0);
        chk("in_zero", 32'(in_m != '0), 32'd0);
        chk("wq_zero", 32'(wq_m != '0), 32'd0);
        chk("wk_zero", 32'(wk_m != '0), 32'd0);
        chk("wv_zero", 32'(wv_m != '0), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(s_if.in_ready), 32'd1);
        for (int k = 0; k < TOTAL; k++) exp_mem[k] = '0;
        sb_q.delete();
    endtask

    task automatic run_frame(input vec_t v);
        logic [WIDTH-1:0] d;
        int               early_start, fd_seen, not_ready, pulses, kept_bad;
        sb_t              e;
        early_start = 0;
        fd_seen     = 0;
        not_ready   = 0;
        for (int k = 0; k < v.nbeats; k++) begin
            if (v.gap) begin
                s_if.in_valid = 1'b0;
                if (v.done_mid && k == v.nbeats / 2) DONE = 1'b1;
                @(posedge clk);
                @(negedge clk);
                DONE = 1'b0;
                fd_seen += int'(frame_done);
                early_start += int'(START);
            end
            d             = WIDTH'(v.base + k);
            s_if.in_valid = 1'b1;
            s_if.in_data  = d;
            reuse_w       = v.reuse;
            if (!s_if.in_ready) not_ready++;
            sb_q.push_back('{idx: k, val: d});
            exp_mem[k] = d;
            @(posedge clk);
            @(negedge clk);
            fd_seen += int'(frame_done);
            if (k < v.nbeats - 1) early_start += int'(START);
        end
        s_if.in_valid = 1'b0;
        chk({v.name, "_ready_during_load"}, 32'(not_ready), 32'd0);
        chk({v.name, "_no_early_start"}, 32'(early_start), 32'd0);
        chk({v.name, "_no_frame_done_in_load"}, 32'(fd_seen), 32'd0);
        chk({v.name, "_start_after_last"}, 32'(START), 32'd1);
        chk({v.name, "_busy_fire"}, 32'(busy), 32'd1);
        chk({v.name, "_ready_fire"}, 32'(s_if.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, "_start_one_cycle"}, 32'(START), 32'd0);
        chk({v.name, "_ready_wait"}, 32'(s_if.in_ready), 32'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("%s_elem%0d", v.name, e.idx), 32'(dut_elem(e.idx)), 32'(e.val));
        end
        kept_bad = 0;
        for (int k = v.nbeats; k < TOTAL; k++) begin
            if (dut_elem(k) !== exp_mem[k]) kept_bad++;
        end
        chk({v.name, "_retained"}, 32'(kept_bad), 32'd0);
        pulses = 0;
        for (int i = 0; i < v.hold; i++) begin
            DONE = 1'b1;
            @(posedge clk);
            @(negedge clk);
            pulses += int'(frame_done);
        end
        DONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            pulses += int'(frame_done);
        end
        chk({v.name, "_one_frame_done"}, 32'(pulses), 32'd1);
        chk({v.name, "_ready_idle"}, 32'(s_if.in_ready), 32'd1);
        chk({v.name, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   starts;
        reset         = 1'b1;
        reuse_w       = 1'b0;
        DONE          = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;

        vecs.push_back('{name: "full",      reuse: 0, nbeats: TOTAL, base: 1,  gap: 0, done_mid: 0, hold: 1});
        vecs.push_back('{name: "signed",    reuse: 0, nbeats: TOTAL, base: 65, gap: 1, done_mid: 1, hold: 3});
        vecs.push_back('{name: "toggle",    reuse: 0, nbeats: TOTAL, base: 1,  gap: 1, done_mid: 0, hold: 3});
`ifdef ATTN_LOADER_WEIGHT_REUSE_EN
        vecs.push_back('{name: "reuse",     reuse: 1, nbeats: NE,    base: 100, gap: 0, done_mid: 0, hold: 1});
`else
        vecs.push_back('{name: "reuse_ign", reuse: 1, nbeats: TOTAL, base: 130, gap: 0, done_mid: 0, hold: 2});
`endif

        do_reset(3);
        for (int i = 0; i < vecs.size(); i++) begin
            run_frame(vecs[i]);
            if (i == 0) begin
                chk("in00", 32'(in_m[0][0]), 32'd1);
                chk("in33", 32'(in_m[3][3]), 32'd16);
                chk("wq00", 32'(wq_m[0][0]), 32'd17);
                chk("wk00", 32'(wk_m[0][0]), 32'd33);
                chk("wv33", 32'(wv_m[3][3]), 32'd64);
            end
`ifdef ATTN_LOADER_WEIGHT_REUSE_EN
            if (i == 3) begin
                chk("reuse_in00", 32'(in_m[0][0]), 32'd100);
                chk("reuse_wq00", 32'(wq_m[0][0]), 32'd17);
            end
`endif
        end

        // Reset in the middle of a frame discards it
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s_if.in_valid = 1'b1;
            s_if.in_data  = WIDTH'(200 + k);
            reuse_w       = 1'b0;
        end
        do_reset(2);
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            starts += int'(START);
        end
        chk("no_start_after_mid_reset", 32'(starts), 32'd0);
        chk("idle_after_mid_reset", 32'(busy), 32'd0);
        v = '{name: "post_reset", reuse: 0, nbeats: TOTAL, base: 3, gap: 0, done_mid: 0, hold: 1};
        run_frame(v);

`ifdef ATTN_LOADER_WEIGHT_REUSE_EN
        // Reuse request with no loaded weights still takes a full frame
        do_reset(3);
        v = '{name: "reuse_cold", reuse: 1, nbeats: TOTAL, base: 7, gap: 0, done_mid: 0, hold: 1};
        run_frame(v);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
